// File: rtl/rom_download_ctrl.sv
// -----------------------------------------------------------------------------
// rom_download_ctrl
//
// Takes words from the UART download receiver, buffers them in a small FIFO,
// and commits each one to the instruction ROM after winning the ROM bus with
// a req/gnt handshake. The CPU is held in halt from the first received word
// until the download has been quiet for IDLE_TIMEOUT clocks.
//
// Build option:
//   ROM_DOWNLOAD_VERIFY_EN - when defined, each written word is read back
//                            (RD, CMP states) and a mismatch sets the sticky
//                            verify_err_o. When undefined, verify_err_o is
//                            tied low and rom_rdata_i is ignored.
//
// Parameters:
//   FIFO_DEPTH   - word FIFO depth (power of 2, >= 2)
//   IDLE_TIMEOUT - quiet clocks after the last activity before hold releases
//
// Ports:
//   clk, rst_n        - system clock, async active-low reset
//   wr_en_i           - one-cycle word strobe from the UART receiver
//   wr_addr_i         - ROM byte address of the word (passed through as-is)
//   wr_data_i         - word data
//   bus_req_o         - ROM bus request
//   bus_gnt_i         - ROM bus grant
//   rom_we_o          - ROM write enable, one cycle per word
//   rom_addr_o        - ROM address (holds last value outside WRITE)
//   rom_wdata_o       - ROM write data (holds last value outside WRITE)
//   rom_rdata_i       - ROM read data, one cycle after the address
//   hold_cpu_o        - CPU halt request
//   overflow_o        - sticky: a word was dropped on a full FIFO
//   words_written_o   - wrapping count of ROM writes
//   verify_err_o      - sticky readback mismatch
//
// FSM states:
//   state  | meaning
//   IDLE   | FIFO empty, bus released
//   REQ    | requesting the ROM bus, waiting for grant
//   WRITE  | one-cycle ROM write of the FIFO head, head popped
//   RD     | readback address cycle (verify build only)
//   CMP    | compare readback with written word (verify build only)
// -----------------------------------------------------------------------------
module rom_download_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned IDLE_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        rom_we_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_wdata_o,
  input  logic [31:0] rom_rdata_i,
  output logic        hold_cpu_o,
  output logic        overflow_o,
  output logic [15:0] words_written_o,
  output logic        verify_err_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_TC = CW'(IDLE_TIMEOUT - 1);

`ifdef ROM_DOWNLOAD_VERIFY_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WRITE = 3'd2,
    ST_RD    = 3'd3,
    ST_CMP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Word FIFO. Pointers carry one extra wrap bit so full/empty are distinct.
  // ---------------------------------------------------------------------------
  logic [63:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] occ;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;
  logic        nonempty_after;
  logic [31:0] head_addr;
  logic [31:0] head_data;

  assign occ        = wptr_q - rptr_q;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = (state_q == ST_WRITE);
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok    = wr_en_i && (!fifo_full || pop);
  assign head_addr  = fifo_mem_q[rptr_q[AW-1:0]][63:32];
  assign head_data  = fifo_mem_q[rptr_q[AW-1:0]][31:0];
  // Occupancy after this edge, used for the exit decision out of WRITE.
  assign nonempty_after = (occ > {{AW{1'b0}}, 1'b1}) || push_ok;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wptr_q[AW-1:0]] <= {wr_addr_i, wr_data_i};
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bus_req_o = 1'b0;
    rom_we_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_REQ;
      end
      ST_REQ: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        bus_req_o = 1'b1;
        rom_we_o  = 1'b1;
`ifdef ROM_DOWNLOAD_VERIFY_EN
        state_d   = ST_RD;
`else
        state_d   = nonempty_after ? ST_REQ : ST_IDLE;
`endif
      end
`ifdef ROM_DOWNLOAD_VERIFY_EN
      ST_RD: begin
        bus_req_o = 1'b1;
        state_d   = ST_CMP;
      end
      ST_CMP: begin
        bus_req_o = 1'b1;
        state_d   = (!fifo_empty || push_ok) ? ST_REQ : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ROM address/data: live FIFO head during WRITE, last written word otherwise
  // ---------------------------------------------------------------------------
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] words_q, words_d;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    if (pop) begin
      addr_d  = head_addr;
      data_d  = head_data;
      words_d = words_q + 16'd1;
    end
  end

  assign rom_addr_o      = pop ? head_addr : addr_q;
  assign rom_wdata_o     = pop ? head_data : data_q;
  assign words_written_o = words_q;

  // ---------------------------------------------------------------------------
  // Sticky flags
  // ---------------------------------------------------------------------------
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en_i && fifo_full && !pop) ovf_d = 1'b1;
  end

  assign overflow_o = ovf_q;

`ifdef ROM_DOWNLOAD_VERIFY_EN
  logic verr_q, verr_d;

  always_comb begin
    verr_d = verr_q;
    if ((state_q == ST_CMP) && (rom_rdata_i != data_q)) verr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) verr_q <= 1'b0;
    else        verr_q <= verr_d;
  end

  assign verify_err_o = verr_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^rom_rdata_i;
  assign verify_err_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // CPU hold and quiet-time counter. Any activity (new strobe, queued word,
  // or sequencer busy) restarts the quiet period; the counter parks at the
  // terminal count once reached.
  // ---------------------------------------------------------------------------
  logic          hold_q, hold_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          busy;

  assign busy = !fifo_empty || (state_q != ST_IDLE);

  always_comb begin
    hold_d = hold_q;
    tmo_d  = tmo_q;
    if (wr_en_i) begin
      hold_d = 1'b1;
      tmo_d  = '0;
    end else if (busy) begin
      tmo_d  = '0;
    end else if (tmo_q == TMO_TC) begin
      hold_d = 1'b0;
    end else begin
      tmo_d  = tmo_q + 1'b1;
    end
  end

  assign hold_cpu_o = hold_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
